// File: rtl/uart_rx_frame.sv
// UART receive frame path: 16x oversampled start detection, 7/8 data bits MSB-first,
// always-present parity slot, 1 or 2 stop bits, one parallel byte per frame with error flags.
module uart_rx_frame (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  // Handshake: data_valid is a one-clk strobe with no back-pressure; data_out and the
  // error flags are stable from that strobe until the next one.

  state_t     state, state_next;
  logic       sync1, rxs, rxs_d;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       cfg_len8, cfg_stop2;
  logic [1:0] cfg_ptype;
  logic       par_err_c, frm_err_c;
  logic       finish_pend;

  logic fall, at_half, at_center;
  logic start_entry, confirm, sample_data, sample_par, sample_stop1, sample_stop2, done;
  logic [2:0] last_idx;

  assign fall      = rxs_d & ~rxs;
  assign at_half   = rx_tick && (tick_cnt == HALF_TICK);
  assign at_center = rx_tick && (tick_cnt == LAST_TICK);
  assign last_idx  = cfg_len8 ? 3'd7 : 3'd6;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    start_entry  = 1'b0;
    confirm      = 1'b0;
    sample_data  = 1'b0;
    sample_par   = 1'b0;
    sample_stop1 = 1'b0;
    sample_stop2 = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          start_entry = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        if (at_half) begin
          if (rxs) begin
            state_next = IDLE;
          end else begin
            confirm    = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (at_center) begin
          sample_data = 1'b1;
          if (bit_cnt == last_idx) state_next = PARITY;
        end
      end
      PARITY: begin
        if (at_center) begin
          sample_par = 1'b1;
          state_next = STOP1;
        end
      end
      STOP1: begin
        if (at_center) begin
          sample_stop1 = 1'b1;
          if (cfg_stop2) begin
            state_next = STOP2;
          end else begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      STOP2: begin
        if (at_center) begin
          sample_stop2 = 1'b1;
          done         = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchronizer and edge history idle high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else begin
      if (start_entry || confirm || at_center) tick_cnt <= 4'd0;
      else if (rx_tick && state != IDLE)      tick_cnt <= tick_cnt + 4'd1;
      if (confirm)          bit_cnt <= 3'd0;
      else if (sample_data) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= 8'd0;
      cfg_len8  <= 1'b1;
      cfg_stop2 <= 1'b0;
      cfg_ptype <= 2'b00;
      par_err_c <= 1'b0;
      frm_err_c <= 1'b0;
    end else begin
      if (confirm) begin
        // Zeroed here so 7 shifts leave bit 7 clear in 7-bit mode.
        shift     <= 8'd0;
        cfg_len8  <= data_length;
        cfg_stop2 <= stop_bits;
        cfg_ptype <= parity_type;
        par_err_c <= 1'b0;
        frm_err_c <= 1'b0;
      end
      if (sample_data) shift <= {shift[6:0], rxs};
      if (sample_par) begin
        case (cfg_ptype)
          2'b01:   par_err_c <= ~(^shift ^ rxs);
          2'b10:   par_err_c <= ^shift ^ rxs;
          default: par_err_c <= 1'b0;
        endcase
      end
      if (sample_stop1) frm_err_c <= ~rxs;
      if (sample_stop2) frm_err_c <= frm_err_c | ~rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_pend  <= 1'b0;
      data_valid   <= 1'b0;
      data_out     <= 8'd0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      finish_pend <= done;
      data_valid  <= finish_pend;
      if (confirm) busy <= 1'b1;
      if (finish_pend) begin
        data_out     <= shift;
        parity_error <= par_err_c;
        frame_error  <= frm_err_c;
        busy         <= 1'b0;
      end
    end
  end

endmodule
